// File: rtl/grf_pkg.sv
// Shared widths and defaults for the GRF write-port arbiter.
package grf_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
  localparam int NREQ_DEF = 3;
  localparam int STARVE_LIM_DEF = 4;
endpackage

// File: rtl/grf_wport_arbiter_if.sv
// Writeback requests in, registered GRF write port and busy mask out.
interface grf_wport_arbiter_if #(parameter int NREQ = grf_pkg::NREQ_DEF);
  import grf_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*REG_AW-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   grf_we;
  logic [REG_AW-1:0]      grf_waddr;
  logic [DATA_W-1:0]      grf_wdata;
  logic [NUM_REGS-1:0]    busy_mask;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, grf_we, grf_waddr, grf_wdata, busy_mask
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, grf_we, grf_waddr, grf_wdata, busy_mask
  );
endinterface

// File: rtl/grf_rr_arb.sv
// Round-robin grant over the multi-cycle requesters; combinational grant,
// pointer advances past the winner only when the parent actually uses the grant.
module grf_rr_arb #(
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] req,
  input  logic         use_gnt,
  output logic [M-1:0] gnt,
  output logic         any_gnt
);
  localparam int PW = (M > 1) ? $clog2(M) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    ptr_d   = ptr_q;
    for (int k = 0; k < M; k++) begin
      if (!any_gnt && req[k] && (k >= int'(ptr_q))) begin
        gnt[k]  = 1'b1;
        any_gnt = 1'b1;
        ptr_d   = (k == M-1) ? '0 : PW'(k+1);
      end
    end
    for (int k = 0; k < M; k++) begin
      if (!any_gnt && req[k] && (k < int'(ptr_q))) begin
        gnt[k]  = 1'b1;
        any_gnt = 1'b1;
        ptr_d   = (k == M-1) ? '0 : PW'(k+1);
      end
    end
    if (!use_gnt) begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/grf_wport_arbiter.sv
// Arbitrates NREQ writeback sources onto the single GRF write port.
// Grant is combinational; the write lands one cycle later; losers simply wait (ready low).
module grf_wport_arbiter
  import grf_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                clk,
  input  logic                reset,
  grf_wport_arbiter_if.slave  bus
);
  localparam int M  = NREQ - 1;
  localparam int CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                grf_we_q, grf_we_d;
  logic [REG_AW-1:0]   grf_waddr_q, grf_waddr_d;
  logic [DATA_W-1:0]   grf_wdata_q, grf_wdata_d;
  logic [M-1:0]        rr_gnt;
  logic                rr_any;
  logic                others_vld;
  logic                deny0;
  logic                gnt0;
  logic                use_rr;
  logic [NREQ-1:0]     gnt;
  logic [REG_AW-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] busy;

  assign others_vld = |bus.req_valid[NREQ-1:1];
  // Requester 0 yields one slot once it has starved the others for STARVE_LIM grants.
  assign deny0  = others_vld && (starve_cnt_q == CW'(STARVE_LIM));
  assign gnt0   = reset && bus.req_valid[0] && !deny0;
  assign use_rr = reset && !gnt0 && rr_any;
  assign gnt    = {rr_gnt & {M{use_rr}}, gnt0};

  grf_rr_arb #(.M(M)) u_rr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid[NREQ-1:1]),
    .use_gnt (use_rr),
    .gnt     (rr_gnt),
    .any_gnt (rr_any)
  );

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_addr = bus.req_addr[i*REG_AW +: REG_AW];
        win_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to r0 complete the handshake but never reach the register file.
  always_comb begin
    grf_we_d     = 1'b0;
    grf_waddr_d  = grf_waddr_q;
    grf_wdata_d  = grf_wdata_q;
    starve_cnt_d = starve_cnt_q;
    if ((|gnt) && (win_addr != ZERO_REG)) begin
      grf_we_d    = 1'b1;
      grf_waddr_d = win_addr;
      grf_wdata_d = win_data;
    end
    if (!others_vld || use_rr) begin
      starve_cnt_d = '0;
    end else if (gnt0) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i]) begin
        busy[bus.req_addr[i*REG_AW +: REG_AW]] = 1'b1;
      end
    end
    if (grf_we_q) begin
      busy[grf_waddr_q] = 1'b1;
    end
    busy[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we_q     <= 1'b0;
      grf_waddr_q  <= '0;
      grf_wdata_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      grf_we_q     <= grf_we_d;
      grf_waddr_q  <= grf_waddr_d;
      grf_wdata_q  <= grf_wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.grf_we    = grf_we_q;
  assign bus.grf_waddr = grf_waddr_q;
  assign bus.grf_wdata = grf_wdata_q;
  assign bus.busy_mask = busy;
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter with a per-cycle reference model.
module tb_grf_wport_arbiter;
  import grf_pkg::*;

  localparam int NREQ = 3;
  localparam int LIM  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  grf_wport_arbiter_if #(.NREQ(NREQ)) bus();

  grf_wport_arbiter #(.NREQ(NREQ), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference state: requester-level view of the arbiter.
  int          m_ptr = 1;
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  function automatic bit others_waiting();
    bit o = 1'b0;
    for (int k = 1; k < NREQ; k++) if (bus.req_valid[k]) o = 1'b1;
    return o;
  endfunction

  function automatic int pick();
    if (bus.req_valid[0] && !(others_waiting() && m_starve == LIM)) return 0;
    for (int s = 0; s < NREQ-1; s++) begin
      int k = 1 + ((m_ptr - 1 + s) % (NREQ - 1));
      if (bus.req_valid[k]) return k;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [31:0] eb;
    logic [63:0] er;
    logic [4:0]  wa;
    int          w;
    if (!reset) begin
      m_ptr = 1; m_starve = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end
    eb = '0;
    for (int i = 0; i < NREQ; i++) if (bus.req_valid[i]) eb[bus.req_addr[i*5 +: 5]] = 1'b1;
    if (m_we) eb[m_waddr] = 1'b1;
    eb[0] = 1'b0;
    chk("m_busy_mask", bus.busy_mask, eb);
    chk("m_grf_we", bus.grf_we, m_we);
    chk("m_grf_waddr", bus.grf_waddr, m_waddr);
    chk("m_grf_wdata", bus.grf_wdata, m_wdata);
    if (!reset) begin
      chk("m_ready_in_reset", bus.req_ready, 0);
    end else begin
      w  = pick();
      er = (w < 0) ? 64'd0 : (64'd1 << w);
      chk("m_req_ready", bus.req_ready, er);
      if (w == 0 && others_waiting()) m_starve = m_starve + 1;
      else if (w > 0 || !others_waiting()) m_starve = 0;
      if (w > 0) m_ptr = (w == NREQ-1) ? 1 : w + 1;
      m_we = 1'b0;
      if (w >= 0) begin
        wa = bus.req_addr[w*5 +: 5];
        if (wa != 5'd0) begin
          m_we = 1'b1;
          m_waddr = wa;
          m_wdata = bus.req_data[w*32 +: 32];
        end
      end
    end
  end

  task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [31:0] d);
    bus.req_valid[i]       = v;
    bus.req_addr[i*5 +: 5]   = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int rr_seq [4]  = '{2, 4, 2, 4};
  int st_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    reset = 1'b0;
    nxt(); nxt();
    #1;
    chk("rst_we", bus.grf_we, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy_mask, 0);
    reset = 1'b1;

    // Basic write
    set_req(0, 1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("basic_ready", bus.req_ready, 3'b001);
    chk("basic_busy0", bus.busy_mask, 32'h20);
    nxt();
    set_req(0, 0, 5'd5, 32'hDEADBEEF);
    #1;
    chk("basic_we", bus.grf_we, 1);
    chk("basic_waddr", bus.grf_waddr, 5);
    chk("basic_wdata", bus.grf_wdata, 32'hDEADBEEF);
    chk("basic_busy1", bus.busy_mask, 32'h20);
    nxt();
    #1;
    chk("idle_we", bus.grf_we, 0);
    chk("idle_waddr_hold", bus.grf_waddr, 5);

    // Priority
    set_req(0, 1, 5'd3, 32'h33);
    set_req(1, 1, 5'd4, 32'h44);
    #1;
    chk("prio_ready0", bus.req_ready, 3'b001);
    chk("prio_busy", bus.busy_mask, 32'h18);
    nxt();
    set_req(0, 0, 5'd3, 32'h33);
    #1;
    chk("prio_ready1", bus.req_ready, 3'b010);
    chk("prio_waddr0", bus.grf_waddr, 3);
    nxt();
    set_req(1, 0, 5'd4, 32'h44);
    #1;
    chk("prio_waddr1", bus.grf_waddr, 4);
    chk("prio_wdata1", bus.grf_wdata, 32'h44);
    nxt();

    // Reset mid-operation
    set_req(1, 1, 5'd7, 32'h77);
    #1;
    chk("mid_ready", bus.req_ready, 3'b010);
    nxt();
    set_req(1, 0, 5'd7, 32'h77);
    #1;
    chk("mid_we", bus.grf_we, 1);
    chk("mid_waddr", bus.grf_waddr, 7);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", bus.grf_we, 0);
    chk("mid_rst_waddr", bus.grf_waddr, 0);
    chk("mid_rst_wdata", bus.grf_wdata, 0);
    chk("mid_rst_busy", bus.busy_mask, 0);
    set_req(1, 1, 5'd7, 32'h77);
    #1;
    chk("mid_rst_ready", bus.req_ready, 0);
    nxt(); nxt();
    #1;
    chk("mid_discard_we", bus.grf_we, 0);
    reset = 1'b1;

    // Round-robin from a freshly reset pointer
    set_req(1, 1, 5'd10, 32'hA1);
    set_req(2, 1, 5'd11, 32'hA2);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr_ready_%0d", c), bus.req_ready, rr_seq[c]);
      nxt();
    end
    set_req(1, 0, 5'd10, 32'hA1);
    set_req(2, 0, 5'd11, 32'hA2);
    nxt();

    // Starvation
    set_req(0, 1, 5'd20, 32'hB0);
    set_req(1, 1, 5'd21, 32'hB1);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("starve_ready_%0d", c), bus.req_ready, st_seq[c]);
      nxt();
    end
    set_req(0, 0, 5'd20, 32'hB0);
    set_req(1, 0, 5'd21, 32'hB1);
    nxt();

    // Register 0
    set_req(2, 1, 5'd0, 32'h1234);
    #1;
    chk("r0_ready", bus.req_ready, 3'b100);
    chk("r0_busy0", bus.busy_mask, 0);
    nxt();
    set_req(2, 0, 5'd0, 32'h1234);
    #1;
    chk("r0_we", bus.grf_we, 0);
    chk("r0_busy1", bus.busy_mask, 0);
    chk("r0_waddr_hold", bus.grf_waddr, 21);
    nxt(); nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
- Shares the single write port of the 32x32 general register file (GRF) between NREQ writeback sources: requester 0 is the main pipeline W stage; requesters 1..NREQ-1 are multi-cycle units (MDU, late load return).
- Grants one request per cycle and registers the winner onto the GRF write port.
- Exports a busy mask so the hazard unit can stall readers of registers with a write still pending.
- Sits between the writeback sources and the GRF write inputs (WriteEn, RegWrite, WData).

Parameters:
- NREQ, 3, number of requesters; legal range 2..8.
- STARVE_LIM, 4, maximum consecutive requester-0 grants allowed while any other requester is waiting.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*5  destination register; requester i occupies bits [5i+4:5i].
- req_data  in  NREQ*32  write data; requester i occupies bits [32i+31:32i].
- req_ready  out  NREQ  grant; one-hot or zero; combinational.
- grf_we  out  1  GRF write enable (registered).
- grf_waddr  out  5  GRF write register (registered).
- grf_wdata  out  32  GRF write data (registered).
- busy_mask  out  32  bit r set means a write to register r is pending.

Behaviour:
- Handshake:
  - A request transfers when req_valid[i] and req_ready[i] are both high at a rising edge.
  - A requester holds valid, addr and data stable until it is granted.
  - req_ready depends only on req_valid and internal state, never on addr or data.
- Priority:
  - Normally requester 0 wins whenever it is valid.
  - Otherwise the winner is chosen round-robin among 1..NREQ-1, starting at rr_ptr.
  - After a round-robin grant to requester k, rr_ptr becomes the next index after k, wrapping from NREQ-1 to 1.
- Starvation:
  - starve_cnt increments on each requester-0 grant made while any other requester is valid.
  - starve_cnt clears on any grant to a requester other than 0, and in any cycle where no other requester is valid.
  - When starve_cnt == STARVE_LIM, requester 0 is denied for one cycle and the round-robin winner is granted instead.
- Latency:
  - The winner's addr and data are registered into grf_waddr and grf_wdata, and grf_we is set to 1 at the same edge.
  - The GRF write therefore happens one cycle after the grant.
  - grf_we = 0 in any cycle following a cycle with no grant.
  - grf_waddr and grf_wdata hold their last values when grf_we = 0.
- Register 0:
  - A request with addr 0 is granted normally (ready asserted, handshake consumed).
  - The registered grf_we stays 0 for that transfer.
  - busy_mask bit 0 is always 0.
- busy_mask (combinational): OR of
  - a one-hot bit for req_addr of every valid requester, and
  - a one-hot bit for grf_waddr when grf_we = 1.
- Same-address collisions: there is no merging. Requests from different requesters to the same addr are written in grant order, so the later grant overwrites the earlier one.
- Reset:
  - Asserting reset (low), including mid-operation, immediately forces grf_we = 0, grf_waddr = 0, grf_wdata = 0, rr_ptr = 1, starve_cnt = 0.
  - A transfer registered in the same cycle as reset is discarded.
  - req_ready is all-zero while reset is low.
  - The first grant may occur in the first cycle after reset goes high.
- Idle: with no valid requests, req_ready = 0, the state is unchanged, and starve_cnt clears.

Decomposition:
- Shared package (grf_pkg):
  - REG_AW = 5, DATA_W = 32, NUM_REGS = 32, ZERO_REG = 5'd0.
  - Default NREQ and STARVE_LIM constants.
- One sub-module, grf_rr_arb: round-robin pointer plus grant logic over requesters 1..NREQ-1.
  - Outputs a one-hot grant and an any_grant flag.
  - Updates its pointer only when its grant is actually used.

Test Plan:
- Basic write: reset low for 2 cycles, then high; req0 valid with addr 5, data 0xDEADBEEF for 1 cycle -> ready[0] = 1 that cycle; next cycle grf_we = 1, waddr = 5, wdata = 0xDEADBEEF; busy_mask = 0x20 in both cycles.
- Priority: req0 (addr 3) and req1 (addr 4) valid together -> ready = 3'b001; the following cycle req1 is granted once req0 drops; grf writes occur in order reg 3, then reg 4.
- Round-robin: req1 and req2 continuously valid, req0 idle -> grants alternate 1, 2, 1, 2 starting with 1 after reset.
- Starvation: req0 and req1 held valid for 10 cycles -> grant sequence 0,0,0,0,1,0,0,0,0,1 with STARVE_LIM = 4.
- Register 0: req2 with addr 0, data 0x1234 -> ready[2] = 1, grf_we stays 0 next cycle, busy_mask = 0.
- Reset mid-operation: grant req1 (addr 7), then pull reset low before the next edge -> grf_we = 0 immediately; after release, rr_ptr = 1 and busy_mask = 0.
